arb_grant_mux: RTL and testbench

// - Shared-resource end of the round-robin req/grant protocol. Consumes the

---
 rtl/arb_grant_mux_if.sv | 38 +++
 rtl/arb_grant_mux.sv | 148 ++++++++++++++
 tb/tb_arb_grant_mux.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb_grant_mux_if.sv
// Bundle between cores, arbiter, shared memory and the grant mux.
// master: core/arbiter/memory side; slave: the arb_grant_mux itself.
interface arb_grant_mux_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_CORES-1:0]        req;
    logic [NUM_CORES-1:0]        grant;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]           core_rdata;
    logic                        busy;
    logic                        mem_valid;
    logic                        mem_ready;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_we;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_rvalid;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        grant_err;

    modport master (
        output req, grant, core_addr, core_we, core_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  core_ack, core_rdata, busy,
        input  mem_valid, mem_addr, mem_we, mem_wdata, grant_err
    );

    modport slave (
        input  req, grant, core_addr, core_we, core_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output core_ack, core_rdata, busy,
        output mem_valid, mem_addr, mem_we, mem_wdata, grant_err
    );
endinterface

// File: rtl/arb_grant_mux.sv
// Grant mux: latches the granted core as owner, forwards its transaction
// to the shared memory port and returns ack/rdata to that core.
// Ports: clk, rst (async, active-high), bus (arb_grant_mux_if.slave):
//   req/grant/core_* from cores+arbiter, core_ack/core_rdata/busy back,
//   mem_* to/from shared memory, grant_err protocol flag.
// Option: define ARB_GRANT_CHECK_EN to enable the sticky grant_err check;
//   otherwise grant_err is tied 0.
module arb_grant_mux #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input logic            clk,
    input logic            rst,
    arb_grant_mux_if.slave bus
);
    localparam int OW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [OW-1:0]        r_owner;
    logic [NUM_CORES-1:0] r_core_ack;
    logic [DATA_W-1:0]    r_core_rdata;
    logic                 r_busy;
    logic                 r_mem_valid;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_W-1:0]    r_mem_wdata;

    logic [NUM_CORES-1:0] w_qual;
    logic                 w_hit;
    logic [OW-1:0]        w_idx;
    logic [NUM_CORES-1:0] w_ack_vec;

    // Descending scan so the lowest qualified index wins.
    always_comb begin
        w_qual = bus.grant & bus.req;
        w_hit  = 1'b0;
        w_idx  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_hit = 1'b1;
                w_idx = OW'(i);
            end
        end
        w_ack_vec = NUM_CORES'(1) << r_owner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_core_ack   <= '0;
            r_core_rdata <= '0;
            r_busy       <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_owner     <= w_idx;
                        r_mem_addr  <= bus.core_addr[w_idx*ADDR_W +: ADDR_W];
                        r_mem_we    <= bus.core_we[w_idx];
                        r_mem_wdata <= bus.core_wdata[w_idx*DATA_W +: DATA_W];
                        r_mem_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_mem_we) begin
                            r_core_rdata <= '0;
                            r_core_ack   <= w_ack_vec;
                            r_state      <= RESP;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_core_rdata <= bus.mem_rdata;
                        r_core_ack   <= w_ack_vec;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_core_ack <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.core_ack   = r_core_ack;
    assign bus.core_rdata = r_core_rdata;
    assign bus.busy       = r_busy;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;

`ifdef ARB_GRANT_CHECK_EN
    logic r_grant_err;
    logic r_after_resp;
    logic w_multi;
    logic w_unreq;
    logic w_busy_g;

    // The idle cycle right after RESP may still see the arbiter's grant
    // for a requester that has just dropped req; that is legal.
    always_comb begin
        w_multi  = |(bus.grant & (bus.grant - NUM_CORES'(1)));
        w_unreq  = (r_state == IDLE) && !r_after_resp
                   && |(bus.grant & ~bus.req);
        w_busy_g = ((r_state == ISSUE) || (r_state == WAIT))
                   && |bus.grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_err  <= 1'b0;
            r_after_resp <= 1'b0;
        end else begin
            r_after_resp <= (r_state == RESP);
            if (w_multi || w_unreq || w_busy_g)
                r_grant_err <= 1'b1;
        end
    end

    assign bus.grant_err = r_grant_err;
`else
    assign bus.grant_err = 1'b0;
`endif
endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux: write, read, backpressure, busy grant,
// stale grant, reset mid-WAIT, each with hand-computed expectations.
module tb_arb_grant_mux;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef ARB_GRANT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    arb_grant_mux_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) u_if ();

    arb_grant_mux #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int c, input logic [AW-1:0] a,
                            input logic we, input logic [DW-1:0] d);
        u_if.core_addr[c*AW +: AW]  = a;
        u_if.core_we[c]             = we;
        u_if.core_wdata[c*DW +: DW] = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        u_if.req        = '0;
        u_if.grant      = '0;
        u_if.core_addr  = '0;
        u_if.core_we    = '0;
        u_if.core_wdata = '0;
        u_if.mem_ready  = 1'b0;
        u_if.mem_rvalid = 1'b0;
        u_if.mem_rdata  = '0;
        set_core(0, 32'h040, 1'b1, 32'h0055);
        set_core(1, 32'h100, 1'b1, 32'hCAFE);
        set_core(2, 32'h200, 1'b0, 32'h0000);
        set_core(3, 32'h300, 1'b0, 32'h0000);
        tick();
        tick();
        check("rst_valid", 64'(u_if.mem_valid), 64'd0);
        check("rst_busy",  64'(u_if.busy), 64'd0);
        check("rst_ack",   64'(u_if.core_ack), 64'd0);
        check("rst_rdata", 64'(u_if.core_rdata), 64'd0);
        check("rst_addr",  64'(u_if.mem_addr), 64'd0);
        check("rst_err",   64'(u_if.grant_err), 64'd0);
        rst = 1'b0;
        tick();

        // Write by core1
        u_if.mem_ready = 1'b1;
        u_if.req   = 4'b0010;
        u_if.grant = 4'b0010;
        tick();
        u_if.grant = '0;
        check("wr_valid", 64'(u_if.mem_valid), 64'd1);
        check("wr_addr",  64'(u_if.mem_addr), 64'h100);
        check("wr_we",    64'(u_if.mem_we), 64'd1);
        check("wr_wdata", 64'(u_if.mem_wdata), 64'hCAFE);
        check("wr_busy",  64'(u_if.busy), 64'd1);
        check("wr_ack0",  64'(u_if.core_ack), 64'd0);
        tick();
        check("wr_ack",   64'(u_if.core_ack), 64'b0010);
        check("wr_vdrop", 64'(u_if.mem_valid), 64'd0);
        check("wr_rdata", 64'(u_if.core_rdata), 64'd0);
        tick();
        check("wr_ack1",  64'(u_if.core_ack), 64'd0);
        check("wr_idle",  64'(u_if.busy), 64'd0);

        // Stale grant for core1 right after its ack
        u_if.req   = '0;
        u_if.grant = 4'b0010;
        tick();
        u_if.grant = '0;
        check("stale_valid", 64'(u_if.mem_valid), 64'd0);
        check("stale_busy",  64'(u_if.busy), 64'd0);
        check("stale_err",   64'(u_if.grant_err), 64'd0);
        tick();

        // Read by core2
        u_if.req   = 4'b0100;
        u_if.grant = 4'b0100;
        tick();
        u_if.grant = '0;
        check("rd_valid", 64'(u_if.mem_valid), 64'd1);
        check("rd_addr",  64'(u_if.mem_addr), 64'h200);
        check("rd_we",    64'(u_if.mem_we), 64'd0);
        tick();
        check("rd_wait_valid", 64'(u_if.mem_valid), 64'd0);
        check("rd_wait_ack",   64'(u_if.core_ack), 64'd0);
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h1234;
        tick();
        u_if.mem_rvalid = 1'b0;
        u_if.mem_rdata  = 32'hDEAD;
        check("rd_ack",   64'(u_if.core_ack), 64'b0100);
        check("rd_rdata", 64'(u_if.core_rdata), 64'h1234);
        tick();
        check("rd_ack1",  64'(u_if.core_ack), 64'd0);
        check("rd_hold",  64'(u_if.core_rdata), 64'h1234);
        u_if.req = '0;
        tick();

        // Backpressure on core0 write, core3 granted while busy
        u_if.mem_ready = 1'b0;
        u_if.req   = 4'b1001;
        u_if.grant = 4'b0001;
        tick();
        u_if.grant = 4'b1000;
        check("bp_valid0", 64'(u_if.mem_valid), 64'd1);
        check("bp_addr0",  64'(u_if.mem_addr), 64'h040);
        for (int k = 0; k < 3; k++) begin
            tick();
            u_if.grant = '0;
            check("bp_valid", 64'(u_if.mem_valid), 64'd1);
            check("bp_addr",  64'(u_if.mem_addr), 64'h040);
            check("bp_we",    64'(u_if.mem_we), 64'd1);
            check("bp_wdata", 64'(u_if.mem_wdata), 64'h0055);
            check("bp_ack",   64'(u_if.core_ack), 64'd0);
        end
        check("busy_gerr", 64'(u_if.grant_err), 64'(ERR_EXP));
        u_if.mem_ready = 1'b1;
        tick();
        check("bp_ack1", 64'(u_if.core_ack), 64'b0001);
        tick();
        check("bp_ack2", 64'(u_if.core_ack), 64'd0);
        check("bp_idle", 64'(u_if.busy), 64'd0);
        u_if.req = 4'b1000;
        tick();
        check("bg_noack0", 64'(u_if.core_ack), 64'd0);
        check("bg_idle",   64'(u_if.mem_valid), 64'd0);
        u_if.grant = 4'b1000;
        tick();
        u_if.grant = '0;
        check("bg_addr",  64'(u_if.mem_addr), 64'h300);
        check("bg_valid", 64'(u_if.mem_valid), 64'd1);
        tick();
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'hBEEF;
        tick();
        u_if.mem_rvalid = 1'b0;
        check("bg_ack",   64'(u_if.core_ack), 64'b1000);
        check("bg_rdata", 64'(u_if.core_rdata), 64'hBEEF);
        tick();
        check("bg_ack1", 64'(u_if.core_ack), 64'd0);
        u_if.req = '0;
        tick();

        // Reset while waiting for read data
        u_if.req   = 4'b0100;
        u_if.grant = 4'b0100;
        tick();
        u_if.grant = '0;
        tick();
        check("rw_busy", 64'(u_if.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rw_valid", 64'(u_if.mem_valid), 64'd0);
        check("rw_busy0", 64'(u_if.busy), 64'd0);
        check("rw_ack",   64'(u_if.core_ack), 64'd0);
        check("rw_err",   64'(u_if.grant_err), 64'd0);
        u_if.req = '0;
        tick();
        rst = 1'b0;
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h7777;
        tick();
        tick();
        u_if.mem_rvalid = 1'b0;
        check("rw_ign_ack",  64'(u_if.core_ack), 64'd0);
        check("rw_ign_busy", 64'(u_if.busy), 64'd0);
        check("rw_ign_rd",   64'(u_if.core_rdata), 64'd0);

        // Normal service after reset
        u_if.req   = 4'b0010;
        u_if.grant = 4'b0010;
        tick();
        u_if.grant = '0;
        check("post_addr", 64'(u_if.mem_addr), 64'h100);
        tick();
        check("post_ack", 64'(u_if.core_ack), 64'b0010);
        tick();
        u_if.req = '0;
        check("post_err", 64'(u_if.grant_err), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
